adder_scheduler: RTL and testbench

ADDER_SCHEDULER -- requirements
Module: adder_scheduler

---
 rtl/adder_scheduler.sv | 176 +++++++++++++++++
 tb/tb_adder_scheduler.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_scheduler.sv
// adder_scheduler
//   Two requesters share a single SLICE-bit adder. A granted request is added
//   one slice per cycle (least significant slice first) with the carry rippled
//   between passes, and the finished result is published with a one-cycle
//   done pulse. Arbitration is round-robin, and requests are only looked at
//   while the block is idle.
//
// Parameters
//   WIDTH    operand and sum width in bits
//   SLICE    width of the shared adder slice; passes P = ceil(WIDTH/SLICE)
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   req0, req1       request levels of requester 0 / 1
//   x0, y0, cin0     operands and carry-in of requester 0
//   x1, y1, cin1     operands and carry-in of requester 1
//   gnt0, gnt1       one-cycle grant pulse, only ever in the idle state
//   sum, cout        result and carry out of bit WIDTH-1, held until next done
//   done             one-cycle result-valid pulse
//   done_id          requester that owns the current result
//   busy             high while an operation is in flight
module adder_scheduler #(
    parameter int WIDTH = 34,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done,
    output logic             done_id,
    output logic             busy
);

    localparam int P  = (WIDTH + SLICE - 1) / SLICE;
    localparam int PW = P * SLICE;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0] LAST_PASS = CW'(P - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_pass;
    logic [PW-1:0]    r_x;
    logic [PW-1:0]    r_y;
    logic [PW-1:0]    r_acc;
    logic             r_carry;
    logic             r_id;
    logic             r_last;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_done;
    logic             r_done_id;

    logic             w_idle;
    logic             w_pick1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic [31:0]      w_shamt;
    logic [SLICE-1:0] w_xs;
    logic [SLICE-1:0] w_ys;
    logic [SLICE-1:0] w_s;
    logic             w_c;
    logic [PW-1:0]    w_next_acc;
    logic             w_cout;

    // Grants are decided combinationally in the idle cycle so the requester
    // sees its grant in the same cycle its operands are captured. Gating with
    // rst_n keeps the grants quiet while reset is held.
    assign w_idle  = rst_n && (r_state == IDLE);
    // Requester 1 wins when it is alone, or when both ask and 0 was granted last.
    assign w_pick1 = req1 && (!req0 || !r_last);
    assign w_gnt0  = w_idle && req0 && !w_pick1;
    assign w_gnt1  = w_idle && w_pick1;

    // Operands are zero-extended to a whole number of slices when captured,
    // so the top slice automatically treats bits above WIDTH as zero.
    assign w_shamt = 32'(r_pass) * 32'(SLICE);
    assign w_xs    = SLICE'(r_x >> w_shamt);
    assign w_ys    = SLICE'(r_y >> w_shamt);
    assign {w_c, w_s} = {1'b0, w_xs} + {1'b0, w_ys} + {{SLICE{1'b0}}, r_carry};

    assign w_next_acc = (r_acc & ~(PW'({SLICE{1'b1}}) << w_shamt))
                      | (PW'(w_s) << w_shamt);

    // With zero padding above WIDTH, the carry out of bit WIDTH-1 lands in
    // bit WIDTH of the padded sum; only a perfectly filled top slice uses the
    // slice carry directly.
    generate
        if (PW == WIDTH) begin : g_full_slice
            assign w_cout = w_c;
        end else begin : g_padded_slice
            assign w_cout = w_next_acc[WIDTH];
        end
    endgenerate

    // Controller and datapath registers. The partial sum lives in r_acc and is
    // copied to the visible result only on the final pass, so sum never shows
    // an intermediate value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pass    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_acc     <= '0;
            r_carry   <= 1'b0;
            r_id      <= 1'b0;
            r_last    <= 1'b1;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_x     <= w_gnt1 ? PW'(x1) : PW'(x0);
                        r_y     <= w_gnt1 ? PW'(y1) : PW'(y0);
                        r_carry <= w_gnt1 ? cin1 : cin0;
                        r_id    <= w_gnt1;
                        r_last  <= w_gnt1;
                        r_pass  <= '0;
                        r_acc   <= '0;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_acc   <= w_next_acc;
                    r_carry <= w_c;
                    if (r_pass == LAST_PASS) begin
                        r_sum     <= w_next_acc[WIDTH-1:0];
                        r_cout    <= w_cout;
                        r_done_id <= r_id;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_pass <= r_pass + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign sum     = r_sum;
    assign cout    = r_cout;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_adder_scheduler.sv
// tb_adder_scheduler
//   Self-checking bench for adder_scheduler at default parameters. A
//   cycle-level behavioural model (full-width arithmetic, an operation age
//   counter and a round-robin pointer) predicts every output on every cycle;
//   directed scenarios add hand-computed literal expectations on top.
module tb_adder_scheduler;

    localparam int WIDTH = 34;
    localparam int SLICE = 16;
    localparam int P     = (WIDTH + SLICE - 1) / SLICE;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1;
    logic [WIDTH-1:0] x0, y0, x1, y1;
    logic             cin0, cin1;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             done;
    logic             done_id;
    logic             busy;

    int errors = 0;
    int checks = 0;

    adder_scheduler #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .x0      (x0),
        .y0      (y0),
        .x1      (x1),
        .y1      (y1),
        .cin0    (cin0),
        .cin1    (cin1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sum     (sum),
        .cout    (cout),
        .done    (done),
        .done_id (done_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic r1,
                                 input logic [WIDTH-1:0] ax0, input logic [WIDTH-1:0] ay0,
                                 input logic ac0,
                                 input logic [WIDTH-1:0] ax1, input logic [WIDTH-1:0] ay1,
                                 input logic ac1);
        req0 = r0;
        req1 = r1;
        x0   = ax0;
        y0   = ay0;
        cin0 = ac0;
        x1   = ax1;
        y1   = ay1;
        cin1 = ac1;
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for the DUT, expected an event", name);
    endtask

    // Behavioural model state: whether an operation is in flight, how many
    // cycles ago it was granted, the predicted result, and the held outputs.
    bit               mActive = 1'b0;
    int               mAge = 0;
    bit               mLast = 1'b1;
    logic [WIDTH-1:0] mPendSum = '0;
    logic             mPendCout = 1'b0;
    logic             mPendId = 1'b0;
    logic [WIDTH-1:0] mSum = '0;
    logic             mCout = 1'b0;
    logic             mId = 1'b0;

    // Every cycle, away from the rising edge: predict all outputs from the
    // current inputs and model state, compare, then advance the model to what
    // the coming rising edge does.
    always @(negedge clk) begin : compareProc
        logic         winner;
        logic         anyGrant;
        logic         expG0, expG1, expDone, expBusy;
        logic [WIDTH:0] full;
        if (!rst_n) begin
            checkOutput("reset gnt0", 64'(gnt0), 64'd0);
            checkOutput("reset gnt1", 64'(gnt1), 64'd0);
            checkOutput("reset done", 64'(done), 64'd0);
            checkOutput("reset busy", 64'(busy), 64'd0);
            checkOutput("reset sum", 64'(sum), 64'd0);
            checkOutput("reset cout", 64'(cout), 64'd0);
            checkOutput("reset done_id", 64'(done_id), 64'd0);
            mActive = 1'b0;
            mAge    = 0;
            mLast   = 1'b1;
            mSum    = '0;
            mCout   = 1'b0;
            mId     = 1'b0;
        end else begin
            winner   = 1'b0;
            anyGrant = 1'b0;
            if (!mActive) begin
                if (req0 && req1) begin
                    winner   = ~mLast;
                    anyGrant = 1'b1;
                end else if (req0 || req1) begin
                    winner   = req1;
                    anyGrant = 1'b1;
                end
            end
            expG0   = anyGrant && !winner;
            expG1   = anyGrant && winner;
            expDone = mActive && (mAge == P + 1);
            expBusy = mActive && (mAge >= 1);
            if (expDone) begin
                mSum  = mPendSum;
                mCout = mPendCout;
                mId   = mPendId;
            end
            checkOutput("gnt0", 64'(gnt0), 64'(expG0));
            checkOutput("gnt1", 64'(gnt1), 64'(expG1));
            checkOutput("done", 64'(done), 64'(expDone));
            checkOutput("busy", 64'(busy), 64'(expBusy));
            checkOutput("sum", 64'(sum), 64'(mSum));
            checkOutput("cout", 64'(cout), 64'(mCout));
            checkOutput("done_id", 64'(done_id), 64'(mId));
            if (expDone) begin
                mActive = 1'b0;
            end else if (mActive) begin
                mAge++;
            end else if (anyGrant) begin
                full      = winner ? ({1'b0, x1} + {1'b0, y1} + (WIDTH+1)'(cin1))
                                   : ({1'b0, x0} + {1'b0, y0} + (WIDTH+1)'(cin0));
                mPendSum  = full[WIDTH-1:0];
                mPendCout = full[WIDTH];
                mPendId   = winner;
                mLast     = winner;
                mActive   = 1'b1;
                mAge      = 1;
            end
        end
    end

    // Issue one request, drop it after its grant, wait for done and check the
    // hand-computed result and the grant-to-done latency.
    task automatic runOne(input string tag, input logic who,
                          input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic c, input logic [WIDTH-1:0] expSum,
                          input logic expCout);
        int               gAt;
        int               dAt;
        logic [WIDTH-1:0] s;
        logic             co;
        logic             id;
        gAt = -1;
        dAt = -1;
        s   = '0;
        co  = 1'b0;
        id  = 1'b0;
        if (who) applyStimulus(1'b0, 1'b1, '0, '0, 1'b0, x, y, c);
        else     applyStimulus(1'b1, 1'b0, x, y, c, '0, '0, 1'b0);
        for (int i = 0; i < 20 && dAt < 0; i++) begin
            @(negedge clk);
            if (gAt < 0 && (who ? gnt1 : gnt0)) gAt = i;
            if (done) begin
                dAt = i;
                s   = sum;
                co  = cout;
                id  = done_id;
            end
            @(posedge clk);
            #1;
            if (gAt >= 0) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (gAt < 0 || dAt < 0) begin
            timeoutFail({tag, " done"});
        end else begin
            checkOutput({tag, " latency"}, 64'(dAt - gAt), 64'd4);
            checkOutput({tag, " sum"}, 64'(s), 64'(expSum));
            checkOutput({tag, " cout"}, 64'(co), 64'(expCout));
            checkOutput({tag, " done_id"}, 64'(id), 64'(who));
        end
    endtask

    function automatic logic [WIDTH-1:0] randOperand();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return WIDTH'(t[15:0]);
            2:       return {{(WIDTH-16){1'b0}}, 16'hFFFF};
            default: return t[WIDTH-1:0];
        endcase
    endfunction

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int gIds[$];
        int gCycles[$];
        int g;
        int k;
        int doneCount;
        logic g0, g1;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed single operations with hand-computed results.
        runOne("single", 1'b0, 34'h0_0000_0001, 34'h0_0000_0002, 1'b0, 34'h0_0000_0003, 1'b0);
        runOne("ripple", 1'b1, 34'h3_FFFF_FFFF, 34'h0_0000_0000, 1'b1, 34'h0_0000_0000, 1'b1);
        runOne("boundary", 1'b0, 34'h0_0000_FFFF, 34'h0_0000_0001, 1'b0, 34'h0_0001_0000, 1'b0);

        // Request from 1 raised while busy must wait for the idle cycle after done.
        applyStimulus(1'b1, 1'b0, 34'h0_1234_0000, 34'h0_0000_5678, 1'b0, '0, '0, 1'b0);
        g = -1;
        for (int i = 0; i < 10 && g < 0; i++) begin
            @(negedge clk);
            if (gnt0) g = i;
            @(posedge clk);
            #1;
        end
        if (g < 0) begin
            timeoutFail("busy-req gnt0");
        end else begin
            applyStimulus(1'b0, 1'b1, '0, '0, 1'b0, 34'h2_0000_0001, 34'h1_0000_0001, 1'b1);
            k = -1;
            for (int i = 1; i < 15 && k < 0; i++) begin
                @(negedge clk);
                if (i == 1) checkOutput("busy-req busy", 64'(busy), 64'd1);
                if (gnt1) k = i;
                @(posedge clk);
                #1;
            end
            req1 = 1'b0;
            if (k < 0) timeoutFail("busy-req gnt1");
            else       checkOutput("busy-req gnt1 delay", 64'(k), 64'd5);
        end
        repeat (6) @(posedge clk);
        #1;

        // Both requesters held from reset: grants alternate 0,1,0,1.
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 34'h0_AAAA_5555, 34'h1_0000_0001, 1'b0,
                      34'h2_5555_AAAA, 34'h0_0F0F_0F0F, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                gIds.push_back(gnt1 ? 1 : 0);
                gCycles.push_back(i);
            end
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("alternate count>=4", 64'(gIds.size() >= 4), 64'd1);
        if (gIds.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("alternate id%0d", i), 64'(gIds[i]), 64'(i % 2));
                if (i > 0)
                    checkOutput($sformatf("alternate gap%0d", i),
                                64'(gCycles[i] - gCycles[i-1]), 64'd5);
            end
        end
        repeat (6) @(posedge clk);
        #1;

        // Reset pulsed during the second ADD cycle aborts without a done.
        applyStimulus(1'b1, 1'b0, 34'h0_0000_0100, 34'h0_0000_0200, 1'b0, '0, '0, 1'b0);
        g = -1;
        for (int i = 0; i < 10 && g < 0; i++) begin
            @(negedge clk);
            if (gnt0) g = i;
            @(posedge clk);
            #1;
        end
        req0 = 1'b0;
        if (g < 0) timeoutFail("abort gnt0");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (done) doneCount++;
            checkOutput("abort busy low", 64'(busy), 64'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) doneCount++;
            @(posedge clk);
            #1;
        end
        checkOutput("abort no done", 64'(doneCount), 64'd0);
        applyStimulus(1'b1, 1'b1, 34'h1_2345_6789, 34'h0_1111_1111, 1'b0,
                      34'h3_0000_0000, 34'h0_0000_0001, 1'b0);
        g0 = 1'b0;
        g1 = 1'b0;
        g  = -1;
        for (int i = 0; i < 5 && g < 0; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                g  = i;
                g0 = gnt0;
                g1 = gnt1;
            end
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        if (g < 0) begin
            timeoutFail("post-reset grant");
        end else begin
            checkOutput("post-reset gnt0", 64'(g0), 64'd1);
            checkOutput("post-reset gnt1", 64'(g1), 64'd0);
            k = -1;
            for (int i = 1; i < 10 && k < 0; i++) begin
                @(negedge clk);
                if (done) begin
                    k = i;
                    checkOutput("post-reset sum", 64'(sum), 64'h1_3456_789A);
                    checkOutput("post-reset done_id", 64'(done_id), 64'd0);
                end
                @(posedge clk);
                #1;
            end
            if (k < 0) timeoutFail("post-reset done");
            else       checkOutput("post-reset latency", 64'(k), 64'd4);
        end

        // Randomized traffic: requesters raise requests with fresh operands,
        // hold them until granted (occasionally giving up), plus rare resets.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            g0 = gnt0;
            g1 = gnt1;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
            end
            if (g0) begin
                req0 = 1'b0;
            end else if (req0) begin
                if ($urandom_range(0, 15) == 0) req0 = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req0 = 1'b1;
                x0   = randOperand();
                y0   = randOperand();
                cin0 = 1'($urandom_range(0, 1));
            end
            if (g1) begin
                req1 = 1'b0;
            end else if (req1) begin
                if ($urandom_range(0, 15) == 0) req1 = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req1 = 1'b1;
                x1   = randOperand();
                y1   = randOperand();
                cin1 = 1'($urandom_range(0, 1));
            end
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
